axi_burst_master: RTL

//  AXI4 initiator: turns one software/DMA command into a single INCR burst toward
//  the DDR controller's AXI slave port, at full DATA_WIDTH per beat.

---
 rtl/axi_burst_master_if.sv | 73 +++++++
 rtl/axi_burst_master.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/axi_burst_master_if.sv
// AXI4 master-side bus bundle used by axi_burst_master.
// Carries the five AXI4 channels (AW, W, B, AR, R) and nothing else.
//   master modport : the initiator drives addresses, write data, bready and rready.
//   slave modport  : the DDR controller side drives the readies, B responses and R data.
// Parameters: DATA_WIDTH (bits per beat), ADDR_WIDTH, ID_WIDTH.
interface axi_burst_master_if #(
    parameter int DATA_WIDTH = 256,
    parameter int ADDR_WIDTH = 32,
    parameter int ID_WIDTH   = 8
);
    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    // write address channel
    logic [ID_WIDTH-1:0]   awid;
    logic [ADDR_WIDTH-1:0] awaddr;
    logic [7:0]            awlen;
    logic [2:0]            awsize;
    logic [1:0]            awburst;
    logic                  awvalid;
    logic                  awready;
    // write data channel
    logic [DATA_WIDTH-1:0] wdata;
    logic [STRB_WIDTH-1:0] wstrb;
    logic                  wlast;
    logic                  wvalid;
    logic                  wready;
    // write response channel
    logic [ID_WIDTH-1:0]   bid;
    logic [1:0]            bresp;
    logic                  bvalid;
    logic                  bready;
    // read address channel
    logic [ID_WIDTH-1:0]   arid;
    logic [ADDR_WIDTH-1:0] araddr;
    logic [7:0]            arlen;
    logic [2:0]            arsize;
    logic [1:0]            arburst;
    logic                  arvalid;
    logic                  arready;
    // read data channel
    logic [ID_WIDTH-1:0]   rid;
    logic [DATA_WIDTH-1:0] rdata;
    logic [1:0]            rresp;
    logic                  rlast;
    logic                  rvalid;
    logic                  rready;

    modport master (
        output awid, awaddr, awlen, awsize, awburst, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready,
        output arid, araddr, arlen, arsize, arburst, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready
    );

    modport slave (
        input  awid, awaddr, awlen, awsize, awburst, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready,
        input  arid, araddr, arlen, arsize, arburst, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready
    );
endinterface

// File: rtl/axi_burst_master.sv
// axi_burst_master: turns one command into a single AXI4 INCR burst, one
// transaction outstanding at a time, full DATA_WIDTH per beat (ui_clk domain).
// Ports:
//   clk, resetn            clock, synchronous active-low reset
//   cmd_valid/cmd_ready    command handshake; cmd_wr selects write (1) or read (0),
//                          cmd_addr byte address (beat-aligned internally), cmd_len = beats-1
//   wr_data/wr_strb        write beat payload, handshake wr_valid/wr_ready
//   rd_data/rd_last        read beat payload, handshake rd_valid/rd_ready
//   done/err               one-cycle end-of-command pulse; err qualifies it
//   dbg_state              current FSM state (IDLE=0 AW=1 W=2 B=3 AR=4 R=5 DONE=6)
//   m_axi                  AXI4 master bus (axi_burst_master_if.master)
//
// Handshake rule for every channel here: a transfer happens on a rising clk edge
// where valid and ready are both 1; a raised valid stays up, with its payload
// stable, until that transfer. The W and R user streams are wired straight
// through to the bus, so their stability is the user's and the slave's to keep.
module axi_burst_master #(
    parameter int          DATA_WIDTH = 256,
    parameter int          ADDR_WIDTH = 32,
    parameter int          STRB_WIDTH = DATA_WIDTH / 8,
    parameter int          ID_WIDTH   = 8,
    parameter int unsigned AXI_ID     = 0
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_wr,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [7:0]            cmd_len,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [STRB_WIDTH-1:0] wr_strb,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_last,
    output logic                  rd_valid,
    input  logic                  rd_ready,
    output logic                  done,
    output logic                  err,
    output logic [2:0]            dbg_state,
    axi_burst_master_if.master    m_axi
);

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_AW   = 3'd1;
    localparam logic [2:0] ST_W    = 3'd2;
    localparam logic [2:0] ST_B    = 3'd3;
    localparam logic [2:0] ST_AR   = 3'd4;
    localparam logic [2:0] ST_R    = 3'd5;
    localparam logic [2:0] ST_DONE = 3'd6;

    localparam logic [2:0]            AX_SIZE  = 3'($clog2(STRB_WIDTH));
    localparam logic [ID_WIDTH-1:0]   ID_VAL   = ID_WIDTH'(AXI_ID);
    localparam logic [ADDR_WIDTH-1:0] LOW_MASK = ADDR_WIDTH'(STRB_WIDTH - 1);
    localparam logic [1:0]            RESP_OK  = 2'b00;

    logic [2:0]            state;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [7:0]            len_q;
    logic [7:0]            beat;
    logic                  err_q;

    logic [ADDR_WIDTH-1:0] aligned_addr;
    logic [19:0]           span_end;
    logic                  cross_4k;
    logic                  cmd_hs;
    logic                  in_w;
    logic                  in_r;
    logic                  w_hs;
    logic                  r_hs;
    logic                  last_beat;
    logic                  r_fault;
    logic                  b_fault;

    assign aligned_addr = cmd_addr & ~LOW_MASK;
    // End of the burst relative to the start of its 4KB page. 20 bits holds the
    // worst case (offset 4095 plus 256 beats of a wide bus) without wrapping.
    assign span_end  = 20'(aligned_addr[11:0]) + (20'(cmd_len) + 20'd1) * 20'(STRB_WIDTH);
    assign cross_4k  = (span_end > 20'd4096);

    assign cmd_ready = (state == ST_IDLE);
    assign cmd_hs    = cmd_valid & cmd_ready;
    assign in_w      = (state == ST_W);
    assign in_r      = (state == ST_R);
    assign last_beat = (beat == len_q);
    assign w_hs      = in_w & wr_valid & m_axi.wready;
    assign r_hs      = in_r & m_axi.rvalid & rd_ready;

    // A wrong ID or a last flag that disagrees with our own beat count is
    // reported the same way as a slave error response.
    assign r_fault = (m_axi.rresp != RESP_OK) | (m_axi.rid != ID_VAL) | (m_axi.rlast != last_beat);
    assign b_fault = (m_axi.bresp != RESP_OK) | (m_axi.bid != ID_VAL);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state  <= ST_IDLE;
            addr_q <= '0;
            len_q  <= '0;
            beat   <= '0;
            err_q  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cmd_hs) begin
                        addr_q <= aligned_addr;
                        len_q  <= cmd_len;
                        beat   <= '0;
                        err_q  <= cross_4k;
                        if (cross_4k)    state <= ST_DONE;
                        else if (cmd_wr) state <= ST_AW;
                        else             state <= ST_AR;
                    end
                end
                ST_AW: begin
                    if (m_axi.awready) state <= ST_W;
                end
                ST_W: begin
                    if (w_hs) begin
                        beat <= beat + 8'd1;
                        if (last_beat) state <= ST_B;
                    end
                end
                ST_B: begin
                    if (m_axi.bvalid) begin
                        if (b_fault) err_q <= 1'b1;
                        state <= ST_DONE;
                    end
                end
                ST_AR: begin
                    if (m_axi.arready) state <= ST_R;
                end
                ST_R: begin
                    if (r_hs) begin
                        beat <= beat + 8'd1;
                        if (r_fault) err_q <= 1'b1;
                        // Stop on whichever comes first so a slave that gets
                        // rlast wrong can never hang the engine.
                        if (m_axi.rlast || last_beat) state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // write address channel
    assign m_axi.awid    = ID_VAL;
    assign m_axi.awaddr  = addr_q;
    assign m_axi.awlen   = len_q;
    assign m_axi.awsize  = AX_SIZE;
    assign m_axi.awburst = 2'b01;
    assign m_axi.awvalid = (state == ST_AW);

    // write data: user stream passes straight through while in W
    assign m_axi.wdata   = wr_data;
    assign m_axi.wstrb   = wr_strb;
    assign m_axi.wlast   = in_w & last_beat;
    assign m_axi.wvalid  = in_w & wr_valid;
    assign wr_ready      = in_w & m_axi.wready;

    // write response
    assign m_axi.bready  = (state == ST_B);

    // read address channel
    assign m_axi.arid    = ID_VAL;
    assign m_axi.araddr  = addr_q;
    assign m_axi.arlen   = len_q;
    assign m_axi.arsize  = AX_SIZE;
    assign m_axi.arburst = 2'b01;
    assign m_axi.arvalid = (state == ST_AR);

    // read data: bus passes straight through to the user while in R
    assign rd_data       = m_axi.rdata;
    assign rd_last       = in_r & m_axi.rlast;
    assign rd_valid      = in_r & m_axi.rvalid;
    assign m_axi.rready  = in_r & rd_ready;

    assign done      = (state == ST_DONE);
    assign err       = err_q;
    assign dbg_state = state;

endmodule
